mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arb_rr.sv | 20 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the CPU/debug data-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU MEM-stage port, the debug/loader port and the memory command port.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin pick: on a tie the requester that was not served last wins.
module mem_arb_rr import mem_arb_pkg::*; (
  input  logic   req_cpu,
  input  logic   req_dbg,
  input  owner_e last_owner,
  output logic   gnt_vld,
  output owner_e gnt_owner
);

  always_comb begin
    gnt_vld   = req_cpu | req_dbg;
    gnt_owner = CPU;
    if (req_cpu && req_dbg) begin
      gnt_owner = (last_owner == CPU) ? DBG : CPU;
    end else if (req_dbg) begin
      gnt_owner = DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage and a debug/loader port.
// Each access runs IDLE -> ISSUE -> WAIT(LATENCY-1) -> RESP -> DONE.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [2:0]        WAIT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_e            state, state_nxt;
  owner_e            owner, last_owner, gnt_owner;
  logic              gnt_vld;
  logic              cpu_req;
  logic [2:0]        cnt;
  logic              we_q;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  logic              mem_en_q, mem_we_q, dbg_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, cpu_rdata_q, dbg_rdata_q;

  // cpu_read with cpu_write both high is a store.
  assign cpu_req = bus.cpu_read | bus.cpu_write;

  mem_arb_rr u_rr (
    .req_cpu    (cpu_req),
    .req_dbg    (bus.dbg_req),
    .last_owner (last_owner),
    .gnt_vld    (gnt_vld),
    .gnt_owner  (gnt_owner)
  );

  always_comb begin
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_we    = bus.cpu_write;
    if (gnt_owner == DBG) begin
      sel_addr  = bus.dbg_addr;
      sel_wdata = bus.dbg_wdata;
      sel_we    = bus.dbg_we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture: the memory command registers double as the latched request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner       <= CPU;
      last_owner  <= DBG;
      cnt         <= 3'd0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
    end else begin
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner       <= gnt_owner;
            last_owner  <= gnt_owner;
            we_q        <= sel_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr & WORD_MASK;
            mem_wdata_q <= sel_wdata;
          end
        end
        ISSUE: cnt <= WAIT_LOAD;
        WAIT:  if (cnt != 3'd0) cnt <= cnt - 3'd1;
        // mem_rdata is valid in RESP; only the owner's read register moves.
        RESP: begin
          if (!we_q) begin
            if (owner == CPU) cpu_rdata_q <= bus.mem_rdata;
            else              dbg_rdata_q <= bus.mem_rdata;
          end
          dbg_ack_q <= (owner == DBG);
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_stall = cpu_req & ~((state == DONE) && (owner == CPU));
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a LATENCY=2 instance and a LATENCY=1 instance, each with its own memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Memory models: byte address 80 holds 100; unread cycles return a poison value.
  logic [DW-1:0] mem0 [64] = '{20: 32'd100, default: 32'd0};
  logic [DW-1:0] mem1 [64] = '{20: 32'd100, default: 32'd0};
  logic [DW-1:0] rd0_p [2];
  logic [DW-1:0] rd1;

  always @(posedge clk) begin
    if (bus0.mem_en && bus0.mem_we) mem0[bus0.mem_addr[7:2]] <= bus0.mem_wdata;
    rd0_p[0] <= (bus0.mem_en && !bus0.mem_we) ? mem0[bus0.mem_addr[7:2]] : 32'hDEAD_BEEF;
    rd0_p[1] <= rd0_p[0];
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[7:2]] <= bus1.mem_wdata;
    rd1 <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr[7:2]] : 32'hDEAD_BEEF;
  end
  assign bus0.mem_rdata = rd0_p[1];
  assign bus1.mem_rdata = rd1;

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic chk; logic [DW-1:0] rdata; } rsp_exp_t;

  mem_exp_t q_mem0[$], q_mem1[$];
  rsp_exp_t q_cpu0[$], q_dbg0[$], q_cpu1[$], q_dbg1[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endfunction

  function automatic void fail_event(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  function automatic void exp_mem(int d, int c, logic we, logic [AW-1:0] a, logic [DW-1:0] wd);
    mem_exp_t e;
    e = '{c, we, a, wd};
    if (d == 0) q_mem0.push_back(e); else q_mem1.push_back(e);
  endfunction

  function automatic void exp_cpu(int d, int c, logic chk, logic [DW-1:0] rd);
    rsp_exp_t e;
    e = '{c, chk, rd};
    if (d == 0) q_cpu0.push_back(e); else q_cpu1.push_back(e);
  endfunction

  function automatic void exp_dbg(int d, int c, logic chk, logic [DW-1:0] rd);
    rsp_exp_t e;
    e = '{c, chk, rd};
    if (d == 0) q_dbg0.push_back(e); else q_dbg1.push_back(e);
  endfunction

  // Monitors: pop an expectation whenever a DUT presents an issue or a completion.
  always @(negedge clk) begin
    mem_exp_t me;
    rsp_exp_t re;
    if (reset === 1'b1) begin
      if (bus0.mem_en !== 1'b0) begin
        if (q_mem0.size() == 0) fail_event("mem0 unexpected issue");
        else begin
          me = q_mem0.pop_front();
          check("mem0 issue cycle", cyc, me.cyc);
          check("mem0 we", bus0.mem_we, me.we);
          check("mem0 addr", bus0.mem_addr, me.addr);
          if (me.we) check("mem0 wdata", bus0.mem_wdata, me.wdata);
        end
      end
      if ((bus0.cpu_read || bus0.cpu_write) && bus0.cpu_stall === 1'b0) begin
        if (q_cpu0.size() == 0) fail_event("cpu0 unexpected completion");
        else begin
          re = q_cpu0.pop_front();
          check("cpu0 done cycle", cyc, re.cyc);
          if (re.chk) check("cpu0 rdata", bus0.cpu_rdata, re.rdata);
        end
      end
      if (bus0.dbg_ack !== 1'b0) begin
        if (q_dbg0.size() == 0) fail_event("dbg0 unexpected ack");
        else begin
          re = q_dbg0.pop_front();
          check("dbg0 ack cycle", cyc, re.cyc);
          if (re.chk) check("dbg0 rdata", bus0.dbg_rdata, re.rdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    mem_exp_t me;
    rsp_exp_t re;
    if (reset === 1'b1) begin
      if (bus1.mem_en !== 1'b0) begin
        if (q_mem1.size() == 0) fail_event("mem1 unexpected issue");
        else begin
          me = q_mem1.pop_front();
          check("mem1 issue cycle", cyc, me.cyc);
          check("mem1 we", bus1.mem_we, me.we);
          check("mem1 addr", bus1.mem_addr, me.addr);
          if (me.we) check("mem1 wdata", bus1.mem_wdata, me.wdata);
        end
      end
      if ((bus1.cpu_read || bus1.cpu_write) && bus1.cpu_stall === 1'b0) begin
        if (q_cpu1.size() == 0) fail_event("cpu1 unexpected completion");
        else begin
          re = q_cpu1.pop_front();
          check("cpu1 done cycle", cyc, re.cyc);
          if (re.chk) check("cpu1 rdata", bus1.cpu_rdata, re.rdata);
        end
      end
      if (bus1.dbg_ack !== 1'b0) begin
        if (q_dbg1.size() == 0) fail_event("dbg1 unexpected ack");
        else begin
          re = q_dbg1.pop_front();
          check("dbg1 ack cycle", cyc, re.cyc);
          if (re.chk) check("dbg1 rdata", bus1.dbg_rdata, re.rdata);
        end
      end
    end
  end

  // CPU requester: hold the request until stall drops, release at the DONE edge.
  task automatic cpu_op(input int d, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit done = 1'b0;
    if (d == 0) begin
      bus0.cpu_read = rd; bus0.cpu_write = wr; bus0.cpu_addr = a; bus0.cpu_wdata = wd;
    end else begin
      bus1.cpu_read = rd; bus1.cpu_write = wr; bus1.cpu_addr = a; bus1.cpu_wdata = wd;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = (d == 0) ? (bus0.cpu_stall === 1'b0) : (bus1.cpu_stall === 1'b0);
    end
    if (!done) fail_event("cpu completion timeout");
    @(posedge clk);
    #1;
    if (d == 0) begin bus0.cpu_read = 1'b0; bus0.cpu_write = 1'b0; end
    else begin bus1.cpu_read = 1'b0; bus1.cpu_write = 1'b0; end
  endtask

  task automatic dbg_op(input int d, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit done = 1'b0;
    if (d == 0) begin
      bus0.dbg_req = 1'b1; bus0.dbg_we = we; bus0.dbg_addr = a; bus0.dbg_wdata = wd;
    end else begin
      bus1.dbg_req = 1'b1; bus1.dbg_we = we; bus1.dbg_addr = a; bus1.dbg_wdata = wd;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = (d == 0) ? (bus0.dbg_ack === 1'b1) : (bus1.dbg_ack === 1'b1);
    end
    if (!done) fail_event("dbg ack timeout");
    @(posedge clk);
    #1;
    if (d == 0) bus0.dbg_req = 1'b0; else bus1.dbg_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b0;
    bus0.cpu_read = 0; bus0.cpu_write = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
    bus0.dbg_req = 0; bus0.dbg_we = 0; bus0.dbg_addr = 0; bus0.dbg_wdata = 0;
    bus1.cpu_read = 0; bus1.cpu_write = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
    bus1.dbg_req = 0; bus1.dbg_we = 0; bus1.dbg_addr = 0; bus1.dbg_wdata = 0;

    repeat (3) @(negedge clk);
    check("reset state", dut0.state, IDLE);
    check("reset mem_en", bus0.mem_en, 0);
    check("reset mem_we", bus0.mem_we, 0);
    check("reset mem_addr", bus0.mem_addr, 0);
    check("reset mem_wdata", bus0.mem_wdata, 0);
    check("reset cpu_rdata", bus0.cpu_rdata, 0);
    check("reset dbg_rdata", bus0.dbg_rdata, 0);
    check("reset dbg_ack", bus0.dbg_ack, 0);
    check("reset cpu_stall", bus0.cpu_stall, 0);

    // CPU read right after reset release, then an unaligned read.
    @(posedge clk); #1;
    reset = 1'b1;
    c = cyc; exp_mem(0, c + 1, 0, 80, 0); exp_cpu(0, c + 4, 1, 100);
    cpu_op(0, 1, 0, 80, 0);
    c = cyc; exp_mem(0, c + 1, 0, 80, 0); exp_cpu(0, c + 4, 1, 100);
    cpu_op(0, 1, 0, 83, 0);

    // Store with read and write both high, then read it back.
    c = cyc; exp_mem(0, c + 1, 1, 4, 123); exp_cpu(0, c + 4, 0, 0);
    cpu_op(0, 1, 1, 4, 123);
    c = cyc; exp_mem(0, c + 1, 0, 4, 0); exp_cpu(0, c + 4, 1, 123);
    cpu_op(0, 1, 0, 4, 0);
    check("dbg_rdata untouched by cpu", bus0.dbg_rdata, 0);

    // Fresh reset, then a tie: CPU first, DBG second.
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    c = cyc;
    exp_mem(0, c + 1, 0, 80, 0); exp_cpu(0, c + 4, 1, 100);
    exp_mem(0, c + 6, 0, 80, 0); exp_dbg(0, c + 9, 1, 100);
    fork
      cpu_op(0, 1, 0, 80, 0);
      dbg_op(0, 0, 80, 0);
    join

    // Both held across four accesses: grants alternate CPU, DBG, CPU, DBG.
    c = cyc;
    exp_mem(0, c + 1,  1, 8,  32'hA5); exp_cpu(0, c + 4,  0, 0);
    exp_mem(0, c + 6,  0, 80, 0);      exp_dbg(0, c + 9,  1, 100);
    exp_mem(0, c + 11, 0, 8,  0);      exp_cpu(0, c + 14, 1, 32'hA5);
    exp_mem(0, c + 16, 1, 12, 77);     exp_dbg(0, c + 19, 0, 0);
    fork
      begin cpu_op(0, 0, 1, 8, 32'hA5); cpu_op(0, 1, 0, 8, 0); end
      begin dbg_op(0, 0, 80, 0);        dbg_op(0, 1, 12, 77);  end
    join
    c = cyc; exp_mem(0, c + 1, 0, 12, 0); exp_dbg(0, c + 4, 1, 77);
    dbg_op(0, 0, 12, 0);
    check("cpu_rdata untouched by dbg", bus0.cpu_rdata, 32'hA5);

    // Reset during the WAIT of a debug read aborts it silently.
    c = cyc; exp_mem(0, c + 1, 0, 80, 0);
    bus0.dbg_req = 1'b1; bus0.dbg_we = 1'b0; bus0.dbg_addr = 80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort precondition state", dut0.state, WAIT);
    reset = 1'b0;
    bus0.dbg_req = 1'b0;
    #1;
    check("abort state", dut0.state, IDLE);
    check("abort mem_en", bus0.mem_en, 0);
    check("abort dbg_ack", bus0.dbg_ack, 0);
    check("abort dbg_rdata", bus0.dbg_rdata, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    c = cyc; exp_mem(0, c + 1, 0, 80, 0); exp_cpu(0, c + 4, 1, 100);
    cpu_op(0, 1, 0, 80, 0);
    check("dbg_rdata after abort", bus0.dbg_rdata, 0);

    // LATENCY=1 build: DONE two cycles after ISSUE.
    c = cyc; exp_mem(1, c + 1, 0, 80, 0); exp_cpu(1, c + 3, 1, 100);
    cpu_op(1, 1, 0, 83, 0);
    c = cyc; exp_mem(1, c + 1, 1, 16, 55); exp_dbg(1, c + 3, 0, 0);
    dbg_op(1, 1, 16, 55);
    c = cyc; exp_mem(1, c + 1, 0, 16, 0); exp_dbg(1, c + 3, 1, 55);
    dbg_op(1, 0, 16, 0);
    check("lat1 cpu_rdata kept", bus1.cpu_rdata, 100);

    repeat (5) @(negedge clk);
    check("mem0 pending", q_mem0.size(), 0);
    check("cpu0 pending", q_cpu0.size(), 0);
    check("dbg0 pending", q_dbg0.size(), 0);
    check("mem1 pending", q_mem1.size(), 0);
    check("cpu1 pending", q_cpu1.size(), 0);
    check("dbg1 pending", q_dbg1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
